// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU control unit: FSM states, IR layout,
// opcode/op constants, memory command and write-back select codes.
package cpu_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned REG_W     = 3;
   localparam int unsigned OPCODE_W  = 3;
   localparam int unsigned OP_W      = 2;
   localparam int unsigned MEM_CMD_W = 2;
   localparam int unsigned VSEL_W    = 2;
   localparam int unsigned NSEL_W    = 3;

   typedef enum logic [4:0] {
      ST_RST, ST_IF1, ST_IF2, ST_UPC, ST_DECODE, ST_WIMM, ST_GETA, ST_GETB,
      ST_EXEC, ST_WB, ST_ADDR, ST_LADDR, ST_LDM, ST_LWB, ST_SGETB, ST_SPASS,
      ST_SMEM, ST_HALT
   } state_t;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [OP_W-1:0]     op;
      logic [REG_W-1:0]    rn;
      logic [REG_W-1:0]    rd;
      logic [1:0]          sh;
      logic [REG_W-1:0]    rm;
   } ir_t;

   localparam logic [OPCODE_W-1:0] OPC_MOV  = 3'b110;
   localparam logic [OPCODE_W-1:0] OPC_ALU  = 3'b101;
   localparam logic [OPCODE_W-1:0] OPC_LDR  = 3'b011;
   localparam logic [OPCODE_W-1:0] OPC_STR  = 3'b100;
   localparam logic [OPCODE_W-1:0] OPC_HALT = 3'b111;

   localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
   localparam logic [OP_W-1:0] OP_MOV_SH  = 2'b00;
   localparam logic [OP_W-1:0] OP_MEM     = 2'b00;
   localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
   localparam logic [OP_W-1:0] OP_CMP     = 2'b01;

   localparam logic [MEM_CMD_W-1:0] MEM_NONE  = 2'b00;
   localparam logic [MEM_CMD_W-1:0] MEM_READ  = 2'b01;
   localparam logic [MEM_CMD_W-1:0] MEM_WRITE = 2'b10;

   localparam logic [VSEL_W-1:0] VSEL_DP    = 2'b00;
   localparam logic [VSEL_W-1:0] VSEL_PC    = 2'b01;
   localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b10;
   localparam logic [VSEL_W-1:0] VSEL_IMM8  = 2'b11;

   // One-hot register-number select driven by the FSM
   localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
   localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;
   localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
   localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;

   function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
      return {{(DATA_W-8){v[7]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
      return {{(DATA_W-5){v[4]}}, v};
   endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Control/memory bundle between the CPU controller (master) and the
// datapath plus memory side (slave).
interface cpu_ctrl_if;
   import cpu_pkg::*;

   logic [DATA_W-1:0]    mdata;
   logic [MEM_CMD_W-1:0] mem_cmd;
   logic                 addr_sel;
   logic                 load_pc;
   logic                 reset_pc;
   logic                 load_addr;
   logic [REG_W-1:0]     readnum;
   logic [REG_W-1:0]     writenum;
   logic                 write;
   logic [VSEL_W-1:0]    vsel;
   logic                 loada;
   logic                 loadb;
   logic                 loadc;
   logic                 loads;
   logic                 asel;
   logic                 bsel;
   logic [1:0]           shift;
   logic [1:0]           ALUop;
   logic [DATA_W-1:0]    sximm8;
   logic [DATA_W-1:0]    sximm5;
   logic                 halted;

   modport master (
      input  mdata,
      output mem_cmd, addr_sel, load_pc, reset_pc, load_addr, readnum, writenum,
             write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop,
             sximm8, sximm5, halted
   );

   modport slave (
      output mdata,
      input  mem_cmd, addr_sel, load_pc, reset_pc, load_addr, readnum, writenum,
             write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop,
             sximm8, sximm5, halted
   );
endinterface

// File: rtl/cpu_ctrl_instr_dec.sv
// Instruction decoder: IR field extraction, immediate sign extension and the
// Rn/Rd/Rm register-number mux.
module instr_dec
   import cpu_pkg::*;
(
   input  ir_t                 ir,
   input  logic [NSEL_W-1:0]   nsel,
   output logic [OPCODE_W-1:0] opcode,
   output logic [OP_W-1:0]     op,
   output logic [1:0]          sh,
   output logic [REG_W-1:0]    reg_num,
   output logic [DATA_W-1:0]   sximm5,
   output logic [DATA_W-1:0]   sximm8
);

   assign opcode = ir.opcode;
   assign op     = ir.op;
   assign sh     = ir.sh;
   assign sximm8 = sext8({ir.rd, ir.sh, ir.rm});
   assign sximm5 = sext5({ir.sh, ir.rm});

   always_comb begin
      reg_num = '0;
      case (nsel)
         NSEL_RN: reg_num = ir.rn;
         NSEL_RD: reg_num = ir.rd;
         NSEL_RM: reg_num = ir.rm;
         default: reg_num = '0;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl.sv
// CPU controller: instruction register plus Moore control FSM sequencing
// fetch, decode, execute, load/store and write-back for the datapath.
module cpu_ctrl
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   cpu_ctrl_if.master bus
);

   state_t              state, state_next;
   ir_t                 ir_q;
   logic                ir_load;
   logic [NSEL_W-1:0]   nsel;
   logic [OPCODE_W-1:0] opcode;
   logic [OP_W-1:0]     op;
   logic [1:0]          sh;
   logic [REG_W-1:0]    reg_num;
   logic                is_mov, is_cmp, alu_force;

   instr_dec u_dec (
      .ir      (ir_q),
      .nsel    (nsel),
      .opcode  (opcode),
      .op      (op),
      .sh      (sh),
      .reg_num (reg_num),
      .sximm5  (bus.sximm5),
      .sximm8  (bus.sximm8)
   );

   assign bus.readnum  = reg_num;
   assign bus.writenum = reg_num;

   assign is_mov    = (opcode == OPC_MOV);
   assign is_cmp    = (opcode == OPC_ALU) && (op == OP_CMP);
   // Only ALU instructions pass their op field through to the ALU
   assign alu_force = is_mov || (opcode == OPC_LDR) || (opcode == OPC_STR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_RST;
      else          state <= state_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     ir_q <= '0;
      else if (ir_load) ir_q <= ir_t'(bus.mdata);
   end

   always_comb begin
      state_next    = state;
      ir_load       = 1'b0;
      nsel          = NSEL_NONE;
      bus.mem_cmd   = MEM_NONE;
      bus.addr_sel  = 1'b0;
      bus.load_pc   = 1'b0;
      bus.reset_pc  = 1'b0;
      bus.load_addr = 1'b0;
      bus.write     = 1'b0;
      bus.vsel      = VSEL_DP;
      bus.loada     = 1'b0;
      bus.loadb     = 1'b0;
      bus.loadc     = 1'b0;
      bus.loads     = 1'b0;
      bus.asel      = 1'b0;
      bus.bsel      = 1'b0;
      bus.shift     = sh;
      bus.ALUop     = alu_force ? OP_ADD : op;
      bus.halted    = 1'b0;

      case (state)
         ST_RST: begin
            bus.reset_pc = 1'b1;
            bus.load_pc  = 1'b1;
            state_next   = ST_IF1;
         end
         ST_IF1: begin
            bus.addr_sel = 1'b1;
            bus.mem_cmd  = MEM_READ;
            state_next   = ST_IF2;
         end
         ST_IF2: begin
            bus.addr_sel = 1'b1;
            bus.mem_cmd  = MEM_READ;
            ir_load      = 1'b1;
            state_next   = ST_UPC;
         end
         ST_UPC: begin
            bus.load_pc = 1'b1;
            state_next  = ST_DECODE;
         end
         ST_DECODE: begin
            // Unsupported encodings fall back to fetch (NOP)
            state_next = ST_IF1;
            case (opcode)
               OPC_MOV: begin
                  if (op == OP_MOV_IMM)     state_next = ST_WIMM;
                  else if (op == OP_MOV_SH) state_next = ST_GETB;
               end
               OPC_ALU:  state_next = ST_GETA;
               OPC_LDR:  if (op == OP_MEM) state_next = ST_GETA;
               OPC_STR:  if (op == OP_MEM) state_next = ST_GETA;
               OPC_HALT: state_next = ST_HALT;
               default:  state_next = ST_IF1;
            endcase
         end
         ST_WIMM: begin
            nsel       = NSEL_RN;
            bus.vsel   = VSEL_IMM8;
            bus.write  = 1'b1;
            state_next = ST_IF1;
         end
         ST_GETA: begin
            nsel       = NSEL_RN;
            bus.loada  = 1'b1;
            state_next = (opcode == OPC_ALU) ? ST_GETB : ST_ADDR;
         end
         ST_GETB: begin
            nsel       = NSEL_RM;
            bus.loadb  = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            bus.asel   = is_mov;
            bus.loadc  = 1'b1;
            bus.loads  = is_cmp;
            state_next = is_cmp ? ST_IF1 : ST_WB;
         end
         ST_WB: begin
            nsel       = NSEL_RD;
            bus.vsel   = VSEL_DP;
            bus.write  = 1'b1;
            state_next = ST_IF1;
         end
         ST_ADDR: begin
            bus.bsel   = 1'b1;
            bus.shift  = 2'b00;
            bus.ALUop  = OP_ADD;
            bus.loadc  = 1'b1;
            state_next = ST_LADDR;
         end
         ST_LADDR: begin
            bus.load_addr = 1'b1;
            state_next    = (opcode == OPC_LDR) ? ST_LDM : ST_SGETB;
         end
         ST_LDM: begin
            bus.mem_cmd = MEM_READ;
            state_next  = ST_LWB;
         end
         ST_LWB: begin
            nsel        = NSEL_RD;
            bus.mem_cmd = MEM_READ;
            bus.vsel    = VSEL_MDATA;
            bus.write   = 1'b1;
            state_next  = ST_IF1;
         end
         ST_SGETB: begin
            nsel       = NSEL_RD;
            bus.loadb  = 1'b1;
            state_next = ST_SPASS;
         end
         ST_SPASS: begin
            bus.asel   = 1'b1;
            bus.shift  = 2'b00;
            bus.ALUop  = OP_ADD;
            bus.loadc  = 1'b1;
            state_next = ST_SMEM;
         end
         ST_SMEM: begin
            bus.mem_cmd = MEM_WRITE;
            state_next  = ST_IF1;
         end
         ST_HALT: begin
            bus.halted = 1'b1;
            state_next = ST_HALT;
         end
         default: state_next = ST_RST;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed and random instructions checked cycle by cycle
// against a per-instruction step plan derived from the instruction class.
module tb_cpu_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cpu_ctrl_if bus ();

   cpu_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef enum {S_RST, S_F1, S_F2, S_UPC, S_DEC, S_WIMM, S_RDA, S_RDB, S_EXE,
                 S_WB, S_ADR, S_LAD, S_LDM, S_LWB, S_SRB, S_SPS, S_SMEM, S_HLT} step_e;
   typedef step_e steps_q[$];

   typedef struct packed {
      logic [1:0] mem_cmd;
      logic       addr_sel, load_pc, reset_pc, load_addr;
      logic [2:0] readnum, writenum;
      logic       write;
      logic [1:0] vsel;
      logic       loada, loadb, loadc, loads, asel, bsel;
      logic [1:0] shift, alu_op;
      logic       halted;
   } obs_t;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] prev_ir = '0;

   // Steps executed after the common IF1/IF2/UPC/DECODE prefix
   function automatic steps_q tail_of(input logic [15:0] ins);
      steps_q t;
      t = {};
      if (ins[15:11] == 5'b11010)      t = '{S_WIMM};
      else if (ins[15:11] == 5'b11000) t = '{S_RDB, S_EXE, S_WB};
      else if (ins[15:13] == 3'b101)
         t = (ins[12:11] == 2'b01) ? '{S_RDA, S_RDB, S_EXE} : '{S_RDA, S_RDB, S_EXE, S_WB};
      else if (ins[15:11] == 5'b01100) t = '{S_RDA, S_ADR, S_LAD, S_LDM, S_LWB};
      else if (ins[15:11] == 5'b10000) t = '{S_RDA, S_ADR, S_LAD, S_SRB, S_SPS, S_SMEM};
      return t;
   endfunction

   function automatic int n_steps(input logic [15:0] ins);
      steps_q t;
      t = tail_of(ins);
      return 4 + t.size();
   endfunction

   function automatic step_e step_at(input logic [15:0] ins, input int k);
      steps_q t;
      t = tail_of(ins);
      case (k)
         0: return S_F1;
         1: return S_F2;
         2: return S_UPC;
         3: return S_DEC;
         default: ;
      endcase
      if (ins[15:13] == 3'b111) return S_HLT;
      return t[k-4];
   endfunction

   // Expected outputs and compare mask for one step given the IR content
   task automatic exp_out(input logic [15:0] ir, input step_e st,
                          output obs_t e, output obs_t m);
      logic [2:0] opc;
      opc = ir[15:13];
      e = '0;
      m = '1;
      m.readnum  = '0;
      m.writenum = '0;
      m.addr_sel = 1'b0;
      e.shift  = ir[4:3];
      e.alu_op = (opc == 3'b110 || opc == 3'b011 || opc == 3'b100) ? 2'b00 : ir[12:11];
      case (st)
         S_RST: begin e.load_pc = 1; e.reset_pc = 1; end
         S_F1, S_F2: begin m.addr_sel = 1; e.addr_sel = 1; e.mem_cmd = 2'b01; end
         S_UPC: e.load_pc = 1;
         S_WIMM: begin m.writenum = '1; e.writenum = ir[10:8]; e.vsel = 2'b11; e.write = 1; end
         S_RDA: begin m.readnum = '1; e.readnum = ir[10:8]; e.loada = 1; end
         S_RDB: begin m.readnum = '1; e.readnum = ir[2:0]; e.loadb = 1; end
         S_EXE: begin e.asel = (opc == 3'b110); e.loadc = 1;
                      e.loads = (opc == 3'b101 && ir[12:11] == 2'b01); end
         S_WB: begin m.writenum = '1; e.writenum = ir[7:5]; e.write = 1; end
         S_ADR: begin e.bsel = 1; e.shift = 0; e.alu_op = 0; e.loadc = 1; end
         S_LAD: e.load_addr = 1;
         S_LDM: begin m.addr_sel = 1; e.mem_cmd = 2'b01; end
         S_LWB: begin m.addr_sel = 1; e.mem_cmd = 2'b01; e.vsel = 2'b10;
                      m.writenum = '1; e.writenum = ir[7:5]; e.write = 1; end
         S_SRB: begin m.readnum = '1; e.readnum = ir[7:5]; e.loadb = 1; end
         S_SPS: begin e.asel = 1; e.shift = 0; e.alu_op = 0; e.loadc = 1; end
         S_SMEM: begin m.addr_sel = 1; e.mem_cmd = 2'b10; end
         S_HLT: e.halted = 1;
         default: ;
      endcase
   endtask

   task automatic observe(output obs_t o);
      o = '{mem_cmd: bus.mem_cmd, addr_sel: bus.addr_sel, load_pc: bus.load_pc,
            reset_pc: bus.reset_pc, load_addr: bus.load_addr, readnum: bus.readnum,
            writenum: bus.writenum, write: bus.write, vsel: bus.vsel, loada: bus.loada,
            loadb: bus.loadb, loadc: bus.loadc, loads: bus.loads, asel: bus.asel,
            bsel: bus.bsel, shift: bus.shift, alu_op: bus.ALUop, halted: bus.halted};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o, e, m;
      reset_n = 1'b0;
      bus.mdata = '0;
      #1;
      observe(o); exp_out(16'h0, S_RST, e, m);
      n_cmp++;
      if ((o & m) !== (e & m)) begin n_err++; $display("FAIL reset_hold: got %h want %h", o, e); end
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      tick();
      observe(o); exp_out(16'h0, S_F1, e, m);
      n_cmp++;
      if ((o & m) !== (e & m)) begin n_err++; $display("FAIL reset_release_if1: got %h want %h", o, e); end
      prev_ir = '0;
   endtask

   task automatic test_mov_imm();
      obs_t o, e, m;
      logic [15:0] ins = 16'hD0FB;
      bus.mdata = ins;
      for (int k = 0; k < n_steps(ins); k++) begin
         observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL mov_imm step %0d: got %h want %h", k, o, e); end
         if (k == 4) begin
            n_cmp++;
            if (bus.sximm8 !== 16'hFFFB) begin n_err++; $display("FAIL mov_imm_sximm8: got %h want FFFB", bus.sximm8); end
         end
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      prev_ir = ins;
   endtask

   task automatic test_alu(input logic [15:0] ins, input string name);
      obs_t o, e, m;
      bus.mdata = ins;
      for (int k = 0; k < n_steps(ins); k++) begin
         observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL %s step %0d: got %h want %h", name, k, o, e); end
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      prev_ir = ins;
   endtask

   task automatic test_ldr();
      obs_t o, e, m;
      logic [15:0] ins = 16'h617E;
      bus.mdata = ins;
      for (int k = 0; k < n_steps(ins); k++) begin
         observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL ldr step %0d: got %h want %h", k, o, e); end
         if (k == 5) begin
            n_cmp++;
            if (bus.sximm5 !== 16'hFFFE) begin n_err++; $display("FAIL ldr_sximm5: got %h want FFFE", bus.sximm5); end
         end
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      prev_ir = ins;
   endtask

   task automatic test_str_halt();
      obs_t o, e, m;
      logic [15:0] ins = 16'h8164;
      bus.mdata = ins;
      for (int k = 0; k < n_steps(ins); k++) begin
         observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL str step %0d: got %h want %h", k, o, e); end
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      prev_ir = ins;
      ins = 16'hE000;
      bus.mdata = ins;
      for (int k = 0; k < 16; k++) begin
         observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL halt step %0d: got %h want %h", k, o, e); end
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      prev_ir = ins;
   endtask

   // Run ins up to step stop_k, then assert reset between clock edges
   task automatic test_reset_mid(input logic [15:0] ins, input int stop_k, input string name);
      obs_t o, e, m;
      bus.mdata = ins;
      for (int k = 0; k < stop_k; k++) begin
         tick();
         if (k == 1) bus.mdata = 16'($urandom);
      end
      observe(o); exp_out(ins, step_at(ins, stop_k), e, m);
      n_cmp++;
      if ((o & m) !== (e & m)) begin n_err++; $display("FAIL %s_pre: got %h want %h", name, o, e); end
      #2 reset_n = 1'b0;
      #1;
      observe(o); exp_out(16'h0, S_RST, e, m);
      n_cmp++;
      if ((o & m) !== (e & m)) begin n_err++; $display("FAIL %s_async: got %h want %h", name, o, e); end
      for (int c = 0; c < 2; c++) begin
         tick();
         observe(o);
         n_cmp++;
         if ((o & m) !== (e & m)) begin n_err++; $display("FAIL %s_hold%0d: got %h want %h", name, c, o, e); end
      end
      n_cmp++;
      if (bus.sximm8 !== 16'h0000) begin n_err++; $display("FAIL %s_ir_clear: got %h want 0000", name, bus.sximm8); end
      @(negedge clk) reset_n = 1'b1;
      tick();
      observe(o); exp_out(16'h0, S_F1, e, m);
      n_cmp++;
      if ((o & m) !== (e & m)) begin n_err++; $display("FAIL %s_if1: got %h want %h", name, o, e); end
      prev_ir = '0;
   endtask

   task automatic test_random(input int n);
      obs_t o, e, m;
      logic [15:0] ins;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 6))
            0: ins = {5'b11010, 11'($urandom)};
            1: ins = {5'b11000, 11'($urandom)};
            2: ins = {3'b101, 13'($urandom)};
            3: ins = {5'b01100, 11'($urandom)};
            4: ins = {5'b10000, 11'($urandom)};
            5: ins = {3'($urandom_range(0, 2)), 13'($urandom)};
            default: ins = {3'b110, 2'b01 | 2'($urandom_range(0, 1) << 1), 11'($urandom)};
         endcase
         bus.mdata = ins;
         for (int k = 0; k < n_steps(ins); k++) begin
            observe(o); exp_out((k < 2) ? prev_ir : ins, step_at(ins, k), e, m);
            n_cmp++;
            if ((o & m) !== (e & m)) begin
               n_err++; $display("FAIL random ins %h step %0d: got %h want %h", ins, k, o, e);
            end
            if (k == 3) begin
               n_cmp++;
               if (bus.sximm8 !== 16'($signed(ins[7:0])) || bus.sximm5 !== 16'($signed(ins[4:0]))) begin
                  n_err++; $display("FAIL random_imm ins %h: got %h/%h", ins, bus.sximm8, bus.sximm5);
               end
            end
            tick();
            if (k == 1) bus.mdata = 16'($urandom);
         end
         prev_ir = ins;
      end
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_alu(16'hA148, "add_lsl");
      test_alu(16'hA900, "cmp");
      test_alu(16'hC0B9, "mov_shift");
      test_ldr();
      test_reset_mid(16'hA148, 5, "rst_getb");
      test_reset_mid(16'h8164, 9, "rst_smem");
      test_random(60);
      test_str_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Instruction register, decoder and control FSM that sits directly upstream of the CPU datapath and drives every datapath strobe and select. It fetches a 16-bit instruction from memory, decodes it, and sequences the datapath through execute, load/store and write-back. It also issues memory commands and controls the externally held PC and data-address registers.

Parameters:
DATA_W, 16, instruction and datapath width (only 16 supported).
REG_W, 3, register-number width.

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  asynchronous, active-low reset.
mdata  in  16  memory read data (instruction or load data).
mem_cmd  out  2  memory command: 00 NONE, 01 READ, 10 WRITE.
addr_sel  out  1  1 = memory address from PC, 0 = from data-address register.
load_pc  out  1  PC register load enable.
reset_pc  out  1  selects 0 as next PC value.
load_addr  out  1  data-address register load (from datapath_out[8:0]).
readnum  out  3  register-file read select.
writenum  out  3  register-file write select.
write  out  1  register-file write enable.
vsel  out  2  write-back mux: 00 datapath_out, 01 PC, 10 mdata, 11 sximm8.
loada, loadb, loadc, loads  out  1 each  A/B/C/status register load enables.
asel  out  1  1 = zero into ALU A input.
bsel  out  1  1 = sximm5 into ALU B input.
shift  out  2  shifter op.
ALUop  out  2  ALU op: 00 ADD, 01 CMP, 10 AND, 11 MVN.
sximm8  out  16  sign-extended IR[7:0].
sximm5  out  16  sign-extended IR[4:0].
halted  out  1  high in HALT.

Behaviour:
- IR fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Supported encodings:
  - MOV imm: 110/10.
  - MOV shift: 110/00.
  - ALU: 101/op.
  - LDR: 011/00.
  - STR: 100/00.
  - HALT: 111.
  - Anything else executes as a NOP (DECODE goes to IF1).
- Async reset: state = RST and IR = 0 immediately. RST outputs hold while reset_n is low. The first edge after release moves to IF1.
- Moore outputs are decoded from state and IR. Any strobe not listed for a state is 0. Default values: mem_cmd = 00, vsel = 00, shift = IR.sh, ALUop = IR.op (forced to 00 for MOV, LDR, STR).
- States and outputs:
  - RST: reset_pc = 1, load_pc = 1. Next: IF1.
  - IF1: addr_sel = 1, mem_cmd = READ. Next: IF2.
  - IF2: addr_sel = 1, mem_cmd = READ; IR loads mdata at the end of the cycle. Next: UPC.
  - UPC: load_pc = 1 (PC + 1 is formed externally). Next: DECODE.
  - DECODE: no strobes. Branches by opcode.
  - WIMM: writenum = Rn, vsel = 11, write = 1. Next: IF1.
  - GETA: readnum = Rn, loada = 1. Next: GETB for ALU, ADDR for LDR/STR.
  - GETB: readnum = Rm, loadb = 1. Next: EXEC. MOV shift enters GETB directly from DECODE.
  - EXEC: asel = 1 only for MOV shift; loadc = 1; loads = 1 only for CMP. Next: IF1 for CMP, otherwise WB.
  - WB: writenum = Rd, vsel = 00, write = 1. Next: IF1.
  - ADDR: bsel = 1, shift = 00, ALUop = 00, loadc = 1. Next: LADDR.
  - LADDR: load_addr = 1. Next: LDM for LDR, SGETB for STR.
  - LDM: addr_sel = 0, mem_cmd = READ. Next: LWB.
  - LWB: addr_sel = 0, mem_cmd = READ, vsel = 10, writenum = Rd, write = 1. Next: IF1.
  - SGETB: readnum = Rd, loadb = 1. Next: SPASS.
  - SPASS: asel = 1, bsel = 0, shift = 00, ALUop = 00, loadc = 1. Next: SMEM.
  - SMEM: addr_sel = 0, mem_cmd = WRITE. Next: IF1.
  - HALT: halted = 1, all strobes 0. Stays in HALT until reset.
- Latency from entering IF1 to the next IF1:
  - MOV imm: 5 cycles.
  - CMP: 7 cycles.
  - ALU with write-back: 8 cycles.
  - MOV shift: 7 cycles.
  - LDR: 9 cycles.
  - STR: 10 cycles.
- IR changes only in IF2. readnum and writenum are stable for a whole state.
- Reset in any state, including mid-SMEM: mem_cmd drops to 00 combinationally and no write or load strobe asserts other than load_pc and reset_pc.

Decomposition:
- cpu_pkg holds:
  - the state enum;
  - opcode/op constants;
  - MEM_NONE, MEM_READ, MEM_WRITE;
  - VSEL_* encodings.
- Sub-module instr_dec: combinational IR field extraction, sign extension and Rn/Rd/Rm select mux driven by a 3-bit nsel from the FSM.

Test Plan:
1. Pull reset_n low during GETB -> state = RST at once, reset_pc = load_pc = 1, mem_cmd = 00. Release -> IF1 with mem_cmd = 01 on the next edge.
2. mdata = 16'hD0FB (MOV R0,#-5) -> WIMM shows writenum = 0, vsel = 11, write = 1, sximm8 = 16'hFFFB. IF1 is re-entered 5 cycles later.
3. mdata = 16'hA148 (ADD R2,R1,R0,LSL#1) -> GETA readnum = 1 with loada; GETB readnum = 0 with loadb; EXEC shift = 01, ALUop = 00, loadc = 1, loads = 0; WB writenum = 2, write = 1.
4. mdata = 16'hA900 (CMP R1,R0) -> EXEC ALUop = 01, loads = 1. No WB state; IF1 follows EXEC.
5. mdata = 16'h617E (LDR R3,[R1,#-2]) -> sximm5 = 16'hFFFE; ADDR bsel = 1; LADDR load_addr = 1; LDM/LWB addr_sel = 0, mem_cmd = 01; LWB vsel = 10, writenum = 3, write = 1.
6. mdata = 16'h8164 (STR R3,[R1,#4]) then 16'hE000 -> SGETB readnum = 3; SPASS asel = 1; SMEM mem_cmd = 10, addr_sel = 0. HALT then holds halted = 1 and mem_cmd = 00 for 10 or more cycles.
